vend_ctrl: RTL and testbench
============================

# vend_ctrl

Transaction controller for the vending-machine display path. It sequences goods selection, coin crediting, vend hand-off and change return, and drives the display block's `goods_index`, `money`, `point_flag` and `money_flag` inputs. It sits between the debounced key/coin front end and the pixel generator and dispenser.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 1_500_000_000: inactivity limit in clk cycles (30 s at 50 MHz).
- `CREDIT_MAX`, default 199: credit ceiling in half-yuan units (99.5 yuan).

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `key_next`, `key_prev`, `key_ok`, `key_cancel`, in, 1 each: one-cycle pulses, debounced upstream.
- `coin_valid`, in, 1: one-cycle coin-detect pulse.
- `coin_type`, in, 2: coin value. 1 = 0.5 yuan, 2 = 1 yuan, 3 = 5 yuan. 0 is invalid and is rejected.
- `coin_reject`, out, 1: one-cycle pulse when a coin is not credited.
- `goods_index`, out, 4: selected item. 0 means none; valid items are 1..12.
- `money`, out, 7: integer yuan of credit, equal to credit>>1.
- `point_flag`, out, 1: half-yuan digit of credit, equal to credit[0].
- `money_flag`, out, 2: coin highlight. 0 means none.
- `vend_valid`, out, 1 / `vend_ready`, in, 1: dispense handshake.
- `vend_index`, out, 4: item being dispensed.
- `change_valid`, out, 1 / `change_ready`, in, 1: change handshake, one coin per beat.
- `change_coin`, out, 2: coin to return, encoded as for `coin_type`.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- Internal `credit` is 8 bits, in half-yuan units. Coin values are 1, 2 and 10. Prices come from the package table `PRICE[1..12]`.
- States: IDLE, SELECT, PAY, VEND, CHANGE.
- IDLE: `goods_index`=0, credit=0, `money_flag`=0. `key_next` goes to SELECT with index 1; `key_prev` goes to SELECT with index 12.
- SELECT: `key_next`/`key_prev` step the index and wrap 12→1 and 1→12. `key_next` and `key_prev` in the same cycle leave the index unchanged. `key_ok` goes to PAY and locks the index.
- Coins are credited in SELECT and PAY.
  - A credited coin sets `money_flag` to `coin_type`.
  - If credit plus the coin value would exceed `CREDIT_MAX`, the coin is rejected and credit is unchanged.
  - In IDLE, VEND and CHANGE every coin is rejected.
- PAY: when credit ≥ `PRICE[goods_index]`, go to VEND. If a coin brings credit to the price, VEND is entered the next cycle.
- `key_cancel` in SELECT or PAY goes to CHANGE. If credit is 0 it goes to IDLE instead. If a coin arrives in the same cycle as `key_cancel`, the coin is credited and included in the refund, and cancel wins over entering VEND.
- VEND: `vend_valid`=1 and `vend_index`=`goods_index`, held until `vend_ready`. On the handshake, credit -= price, then go to CHANGE if credit > 0, else IDLE.
- CHANGE: `change_coin` selects the largest coin not exceeding credit:
  - 3 if credit ≥ 10;
  - 2 if credit ≥ 2;
  - otherwise 1.
  - `money_flag` = `change_coin`. On each handshake credit drops by that coin's value. When credit reaches 0, go to IDLE.
- Key presses other than those listed above are ignored.
- Reset mid-transaction clears all state; the credit is lost.

## Timing

- All outputs are registered. Reset values:
  - `goods_index`=0, `money`=0, `point_flag`=0, `money_flag`=0;
  - `vend_valid`=0, `vend_index`=0;
  - `change_valid`=0, `change_coin`=0;
  - `coin_reject`=0, `busy`=0.
- Credit update appears on `money`/`point_flag` one cycle after `coin_valid`.
- `coin_reject` pulses one cycle after the offending `coin_valid`.
- `vend_valid` and `change_valid` rise one cycle after the state is entered and are never dropped before the handshake.
- In CHANGE, a new `change_coin` appears the cycle after each handshake. Back-to-back beats are possible every 2 cycles.

## Configuration

- `VEND_TIMEOUT_EN` defined:
  - A cycle counter runs in SELECT and PAY and restarts on any key or coin event.
  - On reaching `TIMEOUT_CYC-1` it acts as `key_cancel`.
  - It is held at 0 in other states.
- `VEND_TIMEOUT_EN` undefined: no counter and no automatic cancel. `TIMEOUT_CYC` is unused.

## Structure

- Package `vend_pkg` holds:
  - the state encoding;
  - coin codes and the values 1, 2, 10;
  - `PRICE[1..12]` = 3, 4, 5, 6, 7, 8, 10, 12, 14, 16, 20, 30 (half-yuan units);
  - `N_GOODS`=12.
- Sub-module `vend_timer` contains the restartable inactivity counter. It is instantiated only under `VEND_TIMEOUT_EN`.

## Test plan

- **Full purchase with change:** `key_next` ×3, then `key_ok`, then a 5-yuan coin.
  - After the coin, `money`=5 and `point_flag`=0, with `goods_index`=3 throughout.
  - `vend_valid` with `vend_index`=3.
  - After `vend_ready`, the change beats are `change_coin` 2, 2, 1, then IDLE.
- **Wrap and cancel:** `key_prev` from IDLE gives index 12. `key_next` gives 1. Insert 0.5 + 1 yuan, giving `money`=1 and `point_flag`=1. `key_cancel` gives change beats 2, 1, then IDLE.
- **Saturation:** reach credit 198, then insert 1 yuan. `coin_reject` pulses and credit stays 198. A 0.5-yuan coin is accepted, giving `money`=99 and `point_flag`=1.
- **Simultaneous events:**
  - In PAY for item 3 with credit 4, assert a 0.5-yuan coin together with `key_cancel`. There is no VEND, and the refund totals 5 half-units.
  - `key_next` with `key_prev` leaves the index unchanged.
- **Timeout (`VEND_TIMEOUT_EN`, `TIMEOUT_CYC`=100):** idle in PAY with credit 2. At cycle 100 the block enters CHANGE and returns `change_coin` 2. Without the macro it stays in PAY.
- **Reset mid-VEND and coin in VEND:** a coin during VEND gives `coin_reject`. Asserting `rstn` low while `vend_valid` is high clears all outputs to their reset values immediately.

Source files
------------

// File: rtl/vend_pkg.sv
`timescale 1ns/1ps
// vend_pkg: shared encodings for the vending transaction controller.
// Holds the state enum, coin codes and values, the price table, and the coin helper functions.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PAY,
    ST_VEND,
    ST_CHANGE
  } state_e;

  localparam int N_GOODS = 12;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;
  localparam logic [1:0] COIN_FIVE = 2'd3;

  localparam logic [7:0] VAL_HALF = 8'd1;
  localparam logic [7:0] VAL_ONE  = 8'd2;
  localparam logic [7:0] VAL_FIVE = 8'd10;

  // Prices in half-yuan units, indexed by goods_index.
  localparam logic [7:0] PRICE [1:N_GOODS] = '{
    8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd20, 8'd30
  };

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_HALF: coin_value = VAL_HALF;
      COIN_ONE:  coin_value = VAL_ONE;
      COIN_FIVE: coin_value = VAL_FIVE;
      default:   coin_value = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] price_of(input logic [3:0] idx);
    price_of = 8'd0;
    for (int i = 1; i <= N_GOODS; i++) begin
      if (idx == 4'(i)) price_of = PRICE[i];
    end
  endfunction

  // Largest coin that does not exceed the remaining credit.
  function automatic logic [1:0] change_pick(input logic [7:0] credit);
    if (credit >= VAL_FIVE)     change_pick = COIN_FIVE;
    else if (credit >= VAL_ONE) change_pick = COIN_ONE;
    else                        change_pick = COIN_HALF;
  endfunction

endpackage

// File: rtl/vend_if.sv
`timescale 1ns/1ps
// vend_if: key/coin inputs, display outputs and the vend/change handshakes of vend_ctrl.
// master = front end / dispenser side, slave = the controller.
interface vend_if;
  logic       key_next;
  logic       key_prev;
  logic       key_ok;
  logic       key_cancel;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_reject;
  logic [3:0] goods_index;
  logic [6:0] money;
  logic       point_flag;
  logic [1:0] money_flag;
  logic       vend_valid;
  logic       vend_ready;
  logic [3:0] vend_index;
  logic       change_valid;
  logic       change_ready;
  logic [1:0] change_coin;
  logic       busy;

  modport master (
    output key_next, key_prev, key_ok, key_cancel, coin_valid, coin_type,
           vend_ready, change_ready,
    input  coin_reject, goods_index, money, point_flag, money_flag,
           vend_valid, vend_index, change_valid, change_coin, busy
  );

  modport slave (
    input  key_next, key_prev, key_ok, key_cancel, coin_valid, coin_type,
           vend_ready, change_ready,
    output coin_reject, goods_index, money, point_flag, money_flag,
           vend_valid, vend_index, change_valid, change_coin, busy
  );
endinterface

// File: rtl/vend_timer.sv
`timescale 1ns/1ps
// vend_timer: restartable inactivity counter; expire_o is high on the cycle the
// count reaches TIMEOUT_CYC-1 while running. Cleared whenever not running.
module vend_timer #(
  parameter int unsigned TIMEOUT_CYC = 1_500_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic run_i,
  input  logic restart_i,
  output logic expire_o
);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (!run_i || restart_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/vend_ctrl.sv
`timescale 1ns/1ps
// vend_ctrl: selection / payment / vend / change sequencer for the vending display path.
// Define VEND_TIMEOUT_EN to add an inactivity auto-cancel in SELECT and PAY.
module vend_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1_500_000_000,
  parameter int unsigned CREDIT_MAX  = 199
) (
  input logic clk,
  input logic rstn,
  vend_if.slave bus
);
  import vend_pkg::*;

  if (CREDIT_MAX > 255 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("vend_ctrl: CREDIT_MAX must fit 8 bits and TIMEOUT_CYC must be at least 2");
  end

  state_e     state_q;
  logic [3:0] idx_q, vend_index_q;
  logic [7:0] credit_q;
  logic [1:0] money_flag_q, change_coin_q;
  logic       coin_reject_q, vend_valid_q, change_valid_q, busy_q;

  logic [7:0] coin_v, credit_new, price, chg_v, credit_chg, credit_vend;
  logic [8:0] credit_sum;
  logic       in_pay_sel, coin_ok, cancel, timeout;

  always_comb begin
    coin_v      = coin_value(bus.coin_type);
    credit_sum  = {1'b0, credit_q} + {1'b0, coin_v};
    in_pay_sel  = (state_q == ST_SELECT) || (state_q == ST_PAY);
    coin_ok     = bus.coin_valid && (coin_v != 8'd0) && in_pay_sel &&
                  (credit_sum <= 9'(CREDIT_MAX));
    credit_new  = coin_ok ? credit_sum[7:0] : credit_q;
    price       = price_of(idx_q);
    credit_vend = credit_q - price;
    chg_v       = coin_value(change_coin_q);
    credit_chg  = credit_q - chg_v;
    cancel      = bus.key_cancel || timeout;
  end

`ifdef VEND_TIMEOUT_EN
  logic any_evt;
  assign any_evt = bus.key_next || bus.key_prev || bus.key_ok || bus.key_cancel || bus.coin_valid;

  vend_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .run_i     (in_pay_sel),
    .restart_i (any_evt),
    .expire_o  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      idx_q          <= 4'd0;
      credit_q       <= 8'd0;
      money_flag_q   <= COIN_NONE;
      coin_reject_q  <= 1'b0;
      vend_valid_q   <= 1'b0;
      vend_index_q   <= 4'd0;
      change_valid_q <= 1'b0;
      change_coin_q  <= COIN_NONE;
      busy_q         <= 1'b0;
    end else begin
      coin_reject_q <= bus.coin_valid && !coin_ok;
      if (coin_ok) begin
        credit_q     <= credit_new;
        money_flag_q <= bus.coin_type;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.key_next) begin
            state_q <= ST_SELECT;
            idx_q   <= 4'd1;
            busy_q  <= 1'b1;
          end else if (bus.key_prev) begin
            state_q <= ST_SELECT;
            idx_q   <= 4'(N_GOODS);
            busy_q  <= 1'b1;
          end
        end

        ST_SELECT, ST_PAY: begin
          // Cancel outranks everything, including a coin that reaches the price.
          if (cancel) begin
            if (credit_new == 8'd0) begin
              state_q      <= ST_IDLE;
              idx_q        <= 4'd0;
              money_flag_q <= COIN_NONE;
              busy_q       <= 1'b0;
            end else begin
              state_q <= ST_CHANGE;
            end
          end else if (state_q == ST_SELECT) begin
            if (bus.key_ok) begin
              state_q <= ST_PAY;
            end else if (bus.key_next && !bus.key_prev) begin
              idx_q <= (idx_q == 4'(N_GOODS)) ? 4'd1 : idx_q + 4'd1;
            end else if (bus.key_prev && !bus.key_next) begin
              idx_q <= (idx_q == 4'd1) ? 4'(N_GOODS) : idx_q - 4'd1;
            end
          end else if (credit_new >= price) begin
            state_q <= ST_VEND;
          end
        end

        ST_VEND: begin
          if (vend_valid_q && bus.vend_ready) begin
            vend_valid_q <= 1'b0;
            credit_q     <= credit_vend;
            if (credit_vend == 8'd0) begin
              state_q      <= ST_IDLE;
              idx_q        <= 4'd0;
              money_flag_q <= COIN_NONE;
              busy_q       <= 1'b0;
            end else begin
              state_q <= ST_CHANGE;
            end
          end else begin
            vend_valid_q <= 1'b1;
            vend_index_q <= idx_q;
          end
        end

        ST_CHANGE: begin
          // Valid drops for one cycle after every beat, so beats are at most every other cycle.
          if (change_valid_q && bus.change_ready) begin
            change_valid_q <= 1'b0;
            credit_q       <= credit_chg;
            if (credit_chg == 8'd0) begin
              state_q       <= ST_IDLE;
              idx_q         <= 4'd0;
              money_flag_q  <= COIN_NONE;
              change_coin_q <= COIN_NONE;
              busy_q        <= 1'b0;
            end else begin
              change_coin_q <= change_pick(credit_chg);
              money_flag_q  <= change_pick(credit_chg);
            end
          end else if (!change_valid_q) begin
            change_valid_q <= 1'b1;
            change_coin_q  <= change_pick(credit_q);
            money_flag_q   <= change_pick(credit_q);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin_reject  = coin_reject_q;
  assign bus.goods_index  = idx_q;
  assign bus.money        = credit_q[7:1];
  assign bus.point_flag   = credit_q[0];
  assign bus.money_flag   = money_flag_q;
  assign bus.vend_valid   = vend_valid_q;
  assign bus.vend_index   = vend_index_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
`timescale 1ns/1ps
// tb_vend_ctrl: directed scenarios with a scoreboard of expected change beats,
// vend hand-offs and coin rejects, popped by a monitor as the DUT presents them.
module tb_vend_ctrl;
  localparam int unsigned TO_CYC = 100;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vend_if bus ();

  vend_ctrl #(.TIMEOUT_CYC(TO_CYC), .CREDIT_MAX(199)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_change[$];
  int exp_vend[$];
  int exp_rej[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input int act, inout int q[$]);
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event, value %0d", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.change_valid && bus.change_ready) begin
          check_pop("change_coin", int'(bus.change_coin), exp_change);
          check("change_flag", int'(bus.money_flag), int'(bus.change_coin));
        end
        if (bus.vend_valid && bus.vend_ready)
          check_pop("vend_index", int'(bus.vend_index), exp_vend);
        if (bus.coin_reject)
          check_pop("coin_reject", 1, exp_rej);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0d, expected completion", bus.busy);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic kn, input logic kp, input logic ok, input logic cn,
                      input logic cv, input logic [1:0] ct);
    bus.key_next   = kn;
    bus.key_prev   = kp;
    bus.key_ok     = ok;
    bus.key_cancel = cn;
    bus.coin_valid = cv;
    bus.coin_type  = ct;
    @(posedge clk);
    #1;
    bus.key_next   = 1'b0;
    bus.key_prev   = 1'b0;
    bus.key_ok     = 1'b0;
    bus.key_cancel = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'd0;
  endtask

  task automatic coin(input logic [1:0] ct);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ct);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (bus.busy && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, int'(bus.busy), 0);
  endtask

  task automatic push_change(input int credit);
    int c = credit;
    while (c > 0) begin
      if (c >= 10)     begin exp_change.push_back(3); c -= 10; end
      else if (c >= 2) begin exp_change.push_back(2); c -= 2;  end
      else             begin exp_change.push_back(1); c -= 1;  end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_goods"},   int'(bus.goods_index),  0);
    check({tag, "_money"},   int'(bus.money),        0);
    check({tag, "_point"},   int'(bus.point_flag),   0);
    check({tag, "_mflag"},   int'(bus.money_flag),   0);
    check({tag, "_vvalid"},  int'(bus.vend_valid),   0);
    check({tag, "_vindex"},  int'(bus.vend_index),   0);
    check({tag, "_cvalid"},  int'(bus.change_valid), 0);
    check({tag, "_ccoin"},   int'(bus.change_coin),  0);
    check({tag, "_reject"},  int'(bus.coin_reject),  0);
    check({tag, "_busy"},    int'(bus.busy),         0);
  endtask

  initial begin
    bus.key_next = 1'b0; bus.key_prev = 1'b0; bus.key_ok = 1'b0; bus.key_cancel = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_type = 2'd0;
    bus.vend_ready = 1'b0; bus.change_ready = 1'b1;

    #22;
    check_reset_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full purchase with change: item 3 (price 5), pay 10, change 2,2,1.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t1_index", int'(bus.goods_index), 3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    coin(2'd3);
    check("t1_money", int'(bus.money), 5);
    check("t1_point", int'(bus.point_flag), 0);
    check("t1_index_pay", int'(bus.goods_index), 3);
    check("t1_mflag", int'(bus.money_flag), 3);
    exp_vend.push_back(3);
    push_change(5);
    bus.vend_ready = 1'b1;
    wait_idle("t1_idle", 50);
    check("t1_goods_after", int'(bus.goods_index), 0);
    check("t1_money_after", int'(bus.money), 0);
    bus.vend_ready = 1'b0;

    // Wrap and cancel.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t2_prev_idle", int'(bus.goods_index), 12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t2_wrap_next", int'(bus.goods_index), 1);
    coin(2'd1);
    coin(2'd2);
    check("t2_money", int'(bus.money), 1);
    check("t2_point", int'(bus.point_flag), 1);
    push_change(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_idle("t2_idle", 50);

    // Saturation at the credit ceiling.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (19) coin(2'd3);
    repeat (4) coin(2'd2);
    check("t3_money_198", int'(bus.money), 99);
    check("t3_point_198", int'(bus.point_flag), 0);
    exp_rej.push_back(1);
    coin(2'd2);
    check("t3_reject_pulse", int'(bus.coin_reject), 1);
    check("t3_money_rej", int'(bus.money), 99);
    check("t3_point_rej", int'(bus.point_flag), 0);
    coin(2'd1);
    check("t3_money_199", int'(bus.money), 99);
    check("t3_point_199", int'(bus.point_flag), 1);
    check("t3_no_reject", int'(bus.coin_reject), 0);
    push_change(199);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_idle("t3_idle", 200);

    // Coin together with cancel in PAY: refund 5, no vend.
    bus.vend_ready = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    coin(2'd2);
    coin(2'd2);
    check("t4_money", int'(bus.money), 2);
    push_change(5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
    check("t4_no_vend", int'(bus.vend_valid), 0);
    wait_idle("t4_idle", 50);
    bus.vend_ready = 1'b0;

    // key_next with key_prev leaves the index alone; cancel with zero credit goes idle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t4_both_keys", int'(bus.goods_index), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("t4_cancel_zero", int'(bus.busy), 0);

    // Inactivity in PAY with credit 2 (item 1, price 3).
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    coin(2'd2);
    repeat (90) begin @(posedge clk); #1; end
    check("t5_still_pay", int'(bus.change_valid), 0);
    push_change(2);
`ifdef VEND_TIMEOUT_EN
    wait_idle("t5_timeout_idle", 60);
`else
    repeat (60) begin @(posedge clk); #1; end
    check("t5_no_timeout", int'(bus.busy), 1);
    check("t5_index_kept", int'(bus.goods_index), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_idle("t5_cancel_idle", 50);
`endif

    // Coin during VEND is rejected; reset while vend_valid is high clears everything.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    coin(2'd3);
    exp_rej.push_back(1);
    coin(2'd2);
    check("t6_vend_valid", int'(bus.vend_valid), 1);
    check("t6_vend_index", int'(bus.vend_index), 1);
    check("t6_money", int'(bus.money), 5);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("t6_after_rst_busy", int'(bus.busy), 0);

    repeat (3) @(posedge clk);
    #1;
    check("left_change", exp_change.size(), 0);
    check("left_vend", exp_vend.size(), 0);
    check("left_reject", exp_rej.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
